// File: rtl/neuron_mac_par.sv
// neuron_mac_par: LANES-wide fully-connected neuron with saturating MAC,
// runtime bias and identity/ReLU activation, valid/ready in and out.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid/cfg_is_bias     config write strobe, bias(1)/weight(0) select
//   cfg_layer/cfg_neuron      config target; only matching writes apply
//   cfg_data                  weight/bias value (low DATA_W bits)
//   cfg_ready                 config accepted only while idle
//   act_mode                  0 identity, 1 ReLU (sampled in ACT)
//   in_valid/in_data/in_ready input beats, LANES samples per beat
//   out_valid/out_data/out_ready result handshake
//   busy                      high whenever a dot product is in flight
module neuron_mac_par #(
   parameter int NUM_WEIGHT = 784,
   parameter int DATA_W     = 16,
   parameter int FRAC_W     = 14,
   parameter int LANES      = 4,
   parameter int LAYER_ID   = 1,
   parameter int NEURON_ID  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   input  logic                      cfg_is_bias,
   input  logic [31:0]               cfg_layer,
   input  logic [31:0]               cfg_neuron,
   input  logic [31:0]               cfg_data,
   output logic                      cfg_ready,
   input  logic                      act_mode,
   input  logic                      in_valid,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic                      busy
);

   localparam int BEATS     = (NUM_WEIGHT + LANES - 1) / LANES;
   localparam int RW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW        = 2 * DATA_W;
   localparam int SW        = PW + $clog2(LANES);
   localparam int LAST_ROW  = (NUM_WEIGHT - 1) / LANES;
   localparam int LAST_LANE = (NUM_WEIGHT - 1) % LANES;

   typedef enum logic [2:0] {IDLE, ACCUM, BIAS, ACT, OUT} state_t;

   state_t state;

   // weight store: row r holds weights r*LANES .. r*LANES+LANES-1
   logic [DATA_W-1:0] mem [BEATS][LANES];

   logic [RW-1:0]            wr_row;
   logic [LW-1:0]            wr_lane;
   logic signed [DATA_W-1:0] bias_q;
   logic                     cfg_hit;
   logic                     unused_cfg;

   logic [RW-1:0]            rd_row;
   logic                     done;
   logic                     beat;

   logic                     v1;
   logic signed [DATA_W-1:0] x1 [LANES];
   logic signed [DATA_W-1:0] w1 [LANES];
   logic [LANES-1:0]         m1;

   logic                     v2;
   logic signed [PW-1:0]     prod2 [LANES];

   logic signed [SW-1:0]     tree_sum;
   logic signed [PW-1:0]     acc;
   logic signed [PW-1:0]     acc_mac;
   logic signed [PW-1:0]     acc_bias;
   logic signed [SW:0]       bias_ext;

   logic signed [PW-1:0]     sc;
   logic [PW-DATA_W:0]       sc_hi;
   logic [DATA_W-1:0]        scaled;
   logic [DATA_W-1:0]        act_val;

   // clamp a widened sum back into the accumulator range
   function automatic logic signed [PW-1:0] sat_acc(input logic signed [SW:0] v);
      logic [SW-PW+1:0] hi;
      hi = v[SW:PW-1];
      if ((&hi) | ~(|hi))
         sat_acc = v[PW-1:0];
      else if (v[SW])
         sat_acc = {1'b1, {(PW-1){1'b0}}};
      else
         sat_acc = {1'b0, {(PW-1){1'b1}}};
   endfunction

   assign unused_cfg = ^cfg_data[31:DATA_W];
   assign cfg_hit = cfg_valid & cfg_ready
                  & (cfg_layer == 32'(LAYER_ID))
                  & (cfg_neuron == 32'(NEURON_ID));
   assign beat = in_valid & in_ready;

   // weight RAM is deliberately not reset
   always_ff @(posedge clk) begin
      if (cfg_hit && !cfg_is_bias)
         mem[wr_row][wr_lane] <= cfg_data[DATA_W-1:0];
   end

   // write pointer kept as row/lane pair, wrapping after the last weight
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_row  <= '0;
         wr_lane <= '0;
         bias_q  <= '0;
      end else if (cfg_hit) begin
         if (cfg_is_bias) begin
            bias_q <= cfg_data[DATA_W-1:0];
         end else if (wr_row == RW'(LAST_ROW) && wr_lane == LW'(LAST_LANE)) begin
            wr_row  <= '0;
            wr_lane <= '0;
         end else if (wr_lane == LW'(LANES - 1)) begin
            wr_lane <= '0;
            wr_row  <= wr_row + 1'b1;
         end else begin
            wr_lane <= wr_lane + 1'b1;
         end
      end
   end

   // stage 1: weight row read plus lane mask for the ragged final row
   always_ff @(posedge clk) begin
      if (beat) begin
         for (int k = 0; k < LANES; k++) begin
            x1[k] <= in_data[k*DATA_W +: DATA_W];
            w1[k] <= mem[rd_row][k];
            m1[k] <= (rd_row != RW'(LAST_ROW)) || (k <= LAST_LANE);
         end
      end
   end

   // stage 2: lane products
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++)
         prod2[k] <= m1[k] ? PW'(x1[k]) * PW'(w1[k]) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= beat;
         v2 <= v1;
      end
   end

   // stage 3 adder tree and saturating accumulate
   always_comb begin
      tree_sum = '0;
      for (int k = 0; k < LANES; k++)
         tree_sum = tree_sum + SW'(prod2[k]);
   end

   assign acc_mac  = sat_acc((SW+1)'(acc) + (SW+1)'(tree_sum));
   assign bias_ext = (SW+1)'(bias_q) <<< FRAC_W;
   assign acc_bias = sat_acc((SW+1)'(acc) + bias_ext);

   // rescale, saturate to DATA_W, then activation
   always_comb begin
      sc    = acc >>> FRAC_W;
      sc_hi = sc[PW-1:DATA_W-1];
      if ((&sc_hi) | ~(|sc_hi))
         scaled = sc[DATA_W-1:0];
      else if (sc[PW-1])
         scaled = {1'b1, {(DATA_W-1){1'b0}}};
      else
         scaled = {1'b0, {(DATA_W-1){1'b1}}};
      act_val = (act_mode && scaled[DATA_W-1]) ? '0 : scaled;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
         cfg_ready <= 1'b1;
         busy      <= 1'b0;
         rd_row    <= '0;
         done      <= 1'b0;
         acc       <= '0;
      end else begin
         if (beat) begin
            if (rd_row == RW'(LAST_ROW)) begin
               done     <= 1'b1;
               in_ready <= 1'b0;
            end else begin
               rd_row <= rd_row + 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               if (beat) begin
                  state     <= ACCUM;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ACCUM: begin
               if (v2)
                  acc <= acc_mac;
               // last product is being absorbed this cycle
               if (done && !v1)
                  state <= BIAS;
            end
            BIAS: begin
               acc   <= acc_bias;
               state <= ACT;
            end
            ACT: begin
               out_data  <= act_val;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  cfg_ready <= 1'b1;
                  busy      <= 1'b0;
                  rd_row    <= '0;
                  done      <= 1'b0;
                  acc       <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_par.sv
// tb_neuron_mac_par: directed checks of neuron_mac_par with six weights
// over four lanes (two beats, last two lanes of beat 2 masked).
module tb_neuron_mac_par;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_is_bias;
   logic [31:0] cfg_layer;
   logic [31:0] cfg_neuron;
   logic [31:0] cfg_data;
   logic        cfg_ready;
   logic        act_mode;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        busy;

   int errors = 0;
   int checks = 0;

   neuron_mac_par #(
      .NUM_WEIGHT(6), .DATA_W(16), .FRAC_W(14),
      .LANES(4), .LAYER_ID(1), .NEURON_ID(0)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_is_bias(cfg_is_bias),
      .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .act_mode(act_mode),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic is_bias, input int layer,
                            input int neuron, input logic [15:0] d);
      cfg_valid   = 1'b1;
      cfg_is_bias = is_bias;
      cfg_layer   = 32'(layer);
      cfg_neuron  = 32'(neuron);
      cfg_data    = {16'h0, d};
      tick();
      cfg_valid   = 1'b0;
   endtask

   task automatic load_weights(input logic [15:0] w);
      for (int i = 0; i < 6; i++)
         cfg_write(1'b0, 1, 0, w);
   endtask

   // push one beat; returns 0 if in_ready never came
   task automatic send_beat(input logic [63:0] d, output bit ok);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      ok = in_ready;
      tick();
      in_valid = 1'b0;
   endtask

   // two beats then wait for out_valid; lat counts cycles from the
   // final accept cycle to the first out_valid cycle
   task automatic do_run(input logic [63:0] b1, input logic [63:0] b2,
                         input logic mode, output logic [15:0] res,
                         output int lat, output bit ok);
      bit a1, a2;
      act_mode = mode;
      send_beat(b1, a1);
      send_beat(b2, a2);
      lat = 1;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      ok  = a1 && a2 && out_valid;
      res = out_data;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_expect(input string name, input logic [63:0] b1,
                             input logic [63:0] b2, input logic mode,
                             input logic [15:0] exp);
      logic [15:0] r;
      int lat;
      bit ok;
      do_run(b1, b2, mode, r, lat, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout: out_valid never rose", name);
      end
      checks++;
      if (r !== exp) begin
         errors++;
         $display("FAIL %s out_data: got %h want %h", name, r, exp);
      end
      consume();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== 16'h0) begin
         errors++; $display("FAIL reset out_data: got %h want 0000", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset in_ready: got %b want 1", in_ready);
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++; $display("FAIL reset cfg_ready: got %b want 1", cfg_ready);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset busy: got %b want 0", busy);
      end
   endtask

   task automatic test_basic();
      logic [15:0] r;
      int lat;
      bit ok;
      load_weights(16'h4000);
      cfg_write(1'b1, 1, 0, 16'h0000);
      do_run(64'h0400_0400_0400_0400, 64'h7FFF_7FFF_0400_0400, 1'b0, r, lat, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL basic timeout: out_valid never rose");
      end
      checks++;
      if (r !== 16'h1800) begin
         errors++; $display("FAIL basic out_data: got %h want 1800", r);
      end
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL basic latency: got %0d want 5", lat);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic drop out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL basic idle in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_hold();
      logic [15:0] r;
      int lat;
      bit ok;
      do_run(64'h0400_0400_0400_0400, 64'h0000_0000_0400_0400, 1'b0, r, lat, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL hold timeout: out_valid never rose");
      end
      // matching bias write offered while busy must be ignored
      cfg_valid   = 1'b1;
      cfg_is_bias = 1'b1;
      cfg_layer   = 32'd1;
      cfg_neuron  = 32'd0;
      cfg_data    = 32'h0000_4000;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'h1800) begin
            errors++;
            $display("FAIL hold out cyc%0d: got %b/%h want 1/1800", i, out_valid, out_data);
         end
         checks++;
         if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold ready cyc%0d: got in=%b cfg=%b want 0/0", i, in_ready, cfg_ready);
         end
      end
      cfg_valid = 1'b0;
      consume();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold release: got in=%b busy=%b ov=%b want 1/0/0", in_ready, busy, out_valid);
      end
      run_expect("hold bias kept", 64'h0400_0400_0400_0400,
                 64'h0000_0000_0400_0400, 1'b0, 16'h1800);
   endtask

   task automatic test_config();
      cfg_write(1'b1, 1, 1, 16'h4000);
      cfg_write(1'b0, 2, 0, 16'h0000);
      cfg_write(1'b0, 2, 0, 16'h0000);
      run_expect("cfg wrong id", 64'h0400_0400_0400_0400,
                 64'h0000_0000_0400_0400, 1'b0, 16'h1800);
      // pointer wrapped after six loads, so this hits weight 0
      cfg_write(1'b0, 1, 0, 16'h0000);
      run_expect("cfg wrap", 64'h0400_0400_0400_0400,
                 64'h0000_0000_0400_0400, 1'b0, 16'h1400);
   endtask

   task automatic test_bias_relu();
      load_weights(16'h4000);
      cfg_write(1'b1, 1, 0, 16'hC000);
      run_expect("bias identity", 64'h0400_0400_0400_0400,
                 64'h7FFF_7FFF_0400_0400, 1'b0, 16'hD800);
      run_expect("bias relu", 64'h0400_0400_0400_0400,
                 64'h7FFF_7FFF_0400_0400, 1'b1, 16'h0000);
   endtask

   task automatic test_saturation();
      cfg_write(1'b1, 1, 0, 16'h2000);
      run_expect("sat out pos", 64'h2000_2000_2000_2000,
                 64'h2000_2000_2000_2000, 1'b0, 16'h7FFF);
      load_weights(16'h8000);
      run_expect("sat acc pos", 64'h8000_8000_8000_8000,
                 64'h8000_8000_8000_8000, 1'b0, 16'h7FFF);
      run_expect("sat acc neg", 64'h7FFF_7FFF_7FFF_7FFF,
                 64'h7FFF_7FFF_7FFF_7FFF, 1'b0, 16'h8000);
   endtask

   task automatic test_reset_mid();
      bit ok;
      send_beat(64'h0400_0400_0400_0400, ok);
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++; $display("FAIL midrst start: got ok=%b busy=%b want 1/1", ok, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst state: got ov=%b busy=%b in=%b want 0/0/1", out_valid, busy, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst stray out_valid cyc%0d: got 1 want 0", i);
         end
      end
      load_weights(16'h4000);
      run_expect("midrst rerun", 64'h0400_0400_0400_0400,
                 64'h7FFF_7FFF_0400_0400, 1'b0, 16'h1800);
   endtask

   initial begin
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_is_bias = 1'b0;
      cfg_layer = '0;
      cfg_neuron = '0;
      cfg_data = '0;
      act_mode = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_config();
      test_bias_relu();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac_par.md
Name: neuron_mac_par

Overview:
Parametrised successor of the single-lane fully-connected neuron. It computes one dot product over LANES input/weight pairs per beat and adds a runtime-loadable bias. The accumulator, bias add and output stage all saturate. The activation is selected at runtime (identity or ReLU). It sits in a layer array beside other neurons, shares the weight/bias config bus, and uses a valid/ready handshake on input and output so layers can be chained with back-pressure.

Parameters:
NUM_WEIGHT, 784, number of weights/inputs per neuron
DATA_W, 16, signed input/weight/output width
FRAC_W, 14, fractional bits of inputs, weights, bias and output (Q format)
LANES, 4, parallel MAC lanes; inputs per beat
LAYER_ID, 1, layer number this neuron responds to on the config bus
NEURON_ID, 0, neuron number this neuron responds to on the config bus

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  config write strobe
cfg_is_bias  in  1  1 = bias write, 0 = weight write
cfg_layer  in  32  target layer of write
cfg_neuron  in  32  target neuron of write
cfg_data  in  32  weight/bias value; low DATA_W bits used
cfg_ready  out  1  high only in IDLE
act_mode  in  1  0 = identity, 1 = ReLU; sampled in ACT state
in_valid  in  1  input beat valid
in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
in_ready  out  1  beat accept
out_valid  out  1  result valid
out_data  out  DATA_W  activated result
out_ready  in  1  result consumed
busy  out  1  high when not IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: FSM=IDLE, out_valid=0, out_data=0, in_ready=1, cfg_ready=1, busy=0, weight write pointer=0, accumulator=0, bias=0. Weight RAM contents are not cleared.
- Reset mid-operation aborts the dot product. No partial out_valid is produced.
- Config:
  - A write is accepted when cfg_valid & cfg_ready & cfg_layer==LAYER_ID & cfg_neuron==NEURON_ID. All other writes are ignored.
  - Weight write: weight index p = pointer, stored to lane p%LANES, row p/LANES. The pointer increments and wraps to 0 after NUM_WEIGHT-1.
  - Bias write: replaces the DATA_W bias register.
- Depth: BEATS = ceil(NUM_WEIGHT/LANES). On the final beat, lanes with index >= NUM_WEIGHT contribute 0 regardless of data.
- FSM:
  - IDLE: in_ready=1. The first accepted beat moves to ACCUM.
  - ACCUM: in_ready=1 until BEATS beats have been accepted, then 0. Wait for the pipeline to drain, then go to BIAS.
  - BIAS: one cycle, add bias<<FRAC_W to the accumulator with saturation. Go to ACT.
  - ACT: one cycle, apply act_mode and rescale; register out_data; out_valid=1; go to OUT.
  - OUT: hold out_valid and out_data until out_ready, then go to IDLE with out_valid=0. in_ready stays 0 in BIAS, ACT and OUT.
- Pipeline: 3 stages. Stage 1 is a registered weight-row read on the accepted beat. Stage 2 is LANES signed DATA_W×DATA_W products (2*DATA_W each). Stage 3 is the adder tree (2*DATA_W+clog2(LANES) bits), then a saturating add into the 2*DATA_W accumulator.
- Accumulator saturation: clamp to +max (0x7FFF_FFFF for DATA_W=16) or -max (0x8000_0000) when the true sum leaves the range.
- Latency: final beat accepted at cycle T gives out_valid high at T+5 (3 pipeline stages + BIAS + ACT). Beats may have gaps; gaps stall nothing but add cycles.
- Output scaling: result = acc >>> FRAC_W (arithmetic), saturated to signed DATA_W (0x7FFF / 0x8000).
- Activation: identity passes the scaled result. ReLU outputs 0 for a negative result, else the scaled result.
- Simultaneous out_ready and out_valid assertion in the same cycle as entering OUT: the result is consumed. The next beat is accepted the cycle after IDLE is re-entered.
- Config writes during a busy period are not accepted (cfg_ready=0); the upstream bus holds them.

Test Plan:
- NUM_WEIGHT=6, LANES=4: load 6 weights 0x4000 (1.0), bias 0. Send 2 beats, all lanes 0x0400 (beat 2 lanes 2,3 set to 0x7FFF). Identity -> out_data=0x1800 (0.375); out_valid exactly 5 cycles after the 2nd beat is accepted.
- Same weights, bias 0xC000 (-1.0): identity -> 0xD800 (-0.625); ReLU -> 0x0000.
- Inputs 0x2000 (0.5), bias 0x2000: true 3.5 -> out_data=0x7FFF (output saturation). All inputs 0x8000 with weights 0x8000 and NUM_WEIGHT=784 -> accumulator clamps, out_data=0x7FFF, no wrap.
- Hold out_ready=0 for 10 cycles: out_valid and out_data are stable, in_ready=0 and cfg_ready=0 throughout. out_ready=1 -> next cycle IDLE, in_ready=1.
- Config to wrong neuron id and while busy: no RAM or bias change. 7th weight write wraps the pointer to index 0 and overwrites weight 0.
- rst asserted mid-ACCUM (after 1 beat): next cycle out_valid=0, busy=0. A fresh 2-beat run gives the correct 0x1800 result.
